stream_byte_packer: RTL and testbench

Upstream feeder for the 32-bit valid/ready register slice. It accepts an 8-bit byte stream with an end-of-packet marker and packs the bytes little-endian into BYTES-wide words. Each word carries lane-keep and last flags. A one-word assembly buffer and a one-word output register let the input keep streaming while the downstream stage stalls for one word.

---
 rtl/stream_byte_packer.sv | 136 +++++++++++++
 tb/tb_stream_byte_packer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_byte_packer.sv
// Packs an 8-bit byte stream little-endian into BYTES-wide words with keep/last flags.
// One assembly buffer plus one registered output slot absorb a one-word downstream stall.
module stream_byte_packer #(
    parameter int unsigned BYTES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [7:0]           s_data,
    input  logic                 s_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [8*BYTES-1:0]   m_data,
    output logic [BYTES-1:0]     m_keep,
    output logic                 m_last
);

    localparam int unsigned     IW      = $clog2(BYTES);
    localparam int unsigned     DW      = 8 * BYTES;
    localparam logic [IW-1:0]   IDX_MAX = IW'(BYTES - 1);

    logic [DW-1:0]    acc_q,      acc_d;
    logic [BYTES-1:0] acc_keep_q, acc_keep_d;
    logic [IW-1:0]    idx_q,      idx_d;
    logic             acc_full_q, acc_full_d;
    logic             acc_last_q, acc_last_d;

    logic             m_valid_q,  m_valid_d;
    logic [DW-1:0]    m_data_q,   m_data_d;
    logic [BYTES-1:0] m_keep_q,   m_keep_d;
    logic             m_last_q,   m_last_d;

    logic [DW-1:0]    word_w;
    logic [BYTES-1:0] keep_w;
    logic             complete;
    logic             slot_free;
    logic             accept;

    assign s_ready = !acc_full_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_keep  = m_keep_q;
    assign m_last  = m_last_q;

    always_comb begin
        acc_d      = acc_q;
        acc_keep_d = acc_keep_q;
        idx_d      = idx_q;
        acc_full_d = acc_full_q;
        acc_last_d = acc_last_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        m_keep_d   = m_keep_q;
        m_last_d   = m_last_q;

        // Word as it would look with the incoming byte merged into lane idx.
        word_w = acc_q;
        keep_w = acc_keep_q;
        for (int unsigned k = 0; k < BYTES; k++) begin
            if (IW'(k) == idx_q) begin
                word_w[8*k +: 8] = s_data;
                keep_w[k]        = 1'b1;
            end
        end

        complete  = (idx_q == IDX_MAX) || s_last;
        slot_free = !m_valid_q || m_ready;
        accept    = s_valid && !acc_full_q;

        // Output data holds its value; only valid drops when the slot drains with nothing to load.
        if (slot_free) begin
            m_valid_d = 1'b0;
        end

        if (acc_full_q) begin
            if (slot_free) begin
                m_valid_d  = 1'b1;
                m_data_d   = acc_q;
                m_keep_d   = acc_keep_q;
                m_last_d   = acc_last_q;
                acc_d      = '0;
                acc_keep_d = '0;
                acc_last_d = 1'b0;
                acc_full_d = 1'b0;
            end
        end else if (accept) begin
            if (complete) begin
                idx_d = '0;
                if (slot_free) begin
                    m_valid_d  = 1'b1;
                    m_data_d   = word_w;
                    m_keep_d   = keep_w;
                    m_last_d   = s_last;
                    acc_d      = '0;
                    acc_keep_d = '0;
                    acc_last_d = 1'b0;
                end else begin
                    acc_d      = word_w;
                    acc_keep_d = keep_w;
                    acc_last_d = s_last;
                    acc_full_d = 1'b1;
                end
            end else begin
                acc_d      = word_w;
                acc_keep_d = keep_w;
                idx_d      = idx_q + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            acc_keep_q <= '0;
            idx_q      <= '0;
            acc_full_q <= 1'b0;
            acc_last_q <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_keep_q   <= '0;
            m_last_q   <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            acc_keep_q <= acc_keep_d;
            idx_q      <= idx_d;
            acc_full_q <= acc_full_d;
            acc_last_q <= acc_last_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_keep_q   <= m_keep_d;
            m_last_q   <= m_last_d;
        end
    end

endmodule

// File: tb/tb_stream_byte_packer.sv
// Self-checking bench for stream_byte_packer: directed scenarios plus a randomized
// packet stream scored against a chunk-the-packet reference model.
module tb_stream_byte_packer;

    localparam int B = 4;

    typedef struct {
        logic [8*B-1:0] d;
        logic [B-1:0]   k;
        logic           l;
    } word_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic [7:0]     s_data = '0;
    logic           s_last = 1'b0;
    logic           m_valid;
    logic           m_ready = 1'b0;
    logic [8*B-1:0] m_data;
    logic [B-1:0]   m_keep;
    logic           m_last;

    int tests_run = 0;
    int fails = 0;
    word_t got[$];

    stream_byte_packer #(.BYTES(B)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data (s_data),
        .s_last (s_last),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data (m_data),
        .m_keep (m_keep),
        .m_last (m_last)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached (got=%0d required=finish)", $time);
        $fatal(1);
    end

    // Drive one cycle's inputs at negedge, predict transfers at the coming posedge, record output words.
    task automatic cycle(input logic sv, input logic [7:0] sd, input logic sl, input logic mr,
                         output logic in_x);
        word_t w;
        @(negedge clk);
        s_valid = sv; s_data = sd; s_last = sl; m_ready = mr;
        #1;
        in_x = sv && s_ready;
        if (mr && m_valid) begin
            w.d = m_data; w.k = m_keep; w.l = m_last;
            got.push_back(w);
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        got.delete();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        tests_run++;
        if (m_valid !== 1'b0 || m_data !== '0 || m_keep !== '0 || m_last !== 1'b0 || s_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_state: got valid=%b data=%h keep=%b last=%b s_ready=%b required 0/0/0/0/1",
                     m_valid, m_data, m_keep, m_last, s_ready);
        end
    endtask

    task automatic test_steady();
        logic [7:0] bytes_a [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic in_x;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, bytes_a[i], i == 3, 1'b1, in_x);
            tests_run++;
            if (in_x !== 1'b1) begin
                fails++;
                $display("FAIL steady_s_ready[%0d]: got %b required 1", i, in_x);
            end
        end
        #2;
        tests_run++;
        if (m_valid !== 1'b1 || m_data !== 32'h44332211 || m_keep !== 4'b1111 || m_last !== 1'b1) begin
            fails++;
            $display("FAIL steady_word: got v=%b d=%h k=%b l=%b required 1/44332211/1111/1",
                     m_valid, m_data, m_keep, m_last);
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b1, in_x);
    endtask

    task automatic test_partial();
        logic in_x;
        do_reset();
        cycle(1'b1, 8'hAA, 1'b0, 1'b1, in_x);
        cycle(1'b1, 8'hBB, 1'b1, 1'b1, in_x);
        #2;
        tests_run++;
        if (m_valid !== 1'b1 || m_data !== 32'h0000BBAA || m_keep !== 4'b0011 || m_last !== 1'b1) begin
            fails++;
            $display("FAIL partial_word: got v=%b d=%h k=%b l=%b required 1/0000bbaa/0011/1",
                     m_valid, m_data, m_keep, m_last);
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b1, in_x);
        cycle(1'b1, 8'hCC, 1'b1, 1'b1, in_x);
        #2;
        tests_run++;
        if (m_valid !== 1'b1 || m_data !== 32'h000000CC || m_keep !== 4'b0001 || m_last !== 1'b1) begin
            fails++;
            $display("FAIL partial_next_lane0: got v=%b d=%h k=%b l=%b required 1/000000cc/0001/1",
                     m_valid, m_data, m_keep, m_last);
        end
    endtask

    task automatic test_back_pressure();
        logic in_x;
        int   nb = 0;
        do_reset();
        for (int c = 0; c < 11; c++) begin
            cycle(1'b1, 8'(nb + 1), 1'b0, 1'b0, in_x);
            if (in_x) nb++;
        end
        #2;
        tests_run++;
        if (nb !== 8 || s_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_absorb: got accepted=%0d s_ready=%b required 8/0", nb, s_ready);
        end
        tests_run++;
        if (m_valid !== 1'b1 || m_data !== 32'h04030201) begin
            fails++;
            $display("FAIL bp_hold: got v=%b d=%h required 1/04030201", m_valid, m_data);
        end
        cycle(1'b1, 8'd9, 1'b0, 1'b1, in_x);
        tests_run++;
        if (in_x !== 1'b0) begin
            fails++;
            $display("FAIL bp_ninth_early: got accepted=%b required 0", in_x);
        end
        cycle(1'b1, 8'd9, 1'b0, 1'b1, in_x);
        tests_run++;
        if (in_x !== 1'b1 || got.size() != 2) begin
            fails++;
            $display("FAIL bp_recover: got accepted=%b words=%0d required 1/2", in_x, got.size());
        end
        if (got.size() == 2) begin
            tests_run++;
            if (got[0].d !== 32'h04030201 || got[0].k !== 4'hF || got[0].l !== 1'b0 ||
                got[1].d !== 32'h08070605 || got[1].k !== 4'hF || got[1].l !== 1'b0) begin
                fails++;
                $display("FAIL bp_words: got %h/%b/%b %h/%b/%b required 04030201/1111/0 08070605/1111/0",
                         got[0].d, got[0].k, got[0].l, got[1].d, got[1].k, got[1].l);
            end
        end
    endtask

    task automatic test_single_byte();
        logic in_x;
        int   sent = 0;
        int   c = 0;
        do_reset();
        while ((sent < 5 || got.size() < 5) && c < 100) begin
            cycle(sent < 5, 8'(8'hA0 + sent), 1'b1, (c % 2) == 0, in_x);
            if (in_x) sent++;
            c++;
        end
        repeat (4) cycle(1'b0, 8'h00, 1'b0, 1'b1, in_x);
        tests_run++;
        if (got.size() != 5) begin
            fails++;
            $display("FAIL single_count: got %0d words required 5", got.size());
        end
        for (int i = 0; i < got.size() && i < 5; i++) begin
            tests_run++;
            if (got[i].d !== 32'(8'hA0 + i) || got[i].k !== 4'b0001 || got[i].l !== 1'b1) begin
                fails++;
                $display("FAIL single_word[%0d]: got %h/%b/%b required %h/0001/1",
                         i, got[i].d, got[i].k, got[i].l, 32'(8'hA0 + i));
            end
        end
    endtask

    task automatic test_mid_reset();
        logic in_x;
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, in_x);
        cycle(1'b1, 8'h60, 1'b0, 1'b0, in_x);
        cycle(1'b1, 8'h61, 1'b0, 1'b0, in_x);
        @(negedge clk);
        s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (m_valid !== 1'b0 || m_data !== '0 || m_keep !== '0 || m_last !== 1'b0 || s_ready !== 1'b1) begin
            fails++;
            $display("FAIL midreset_async: got v=%b d=%h k=%b l=%b s_ready=%b required 0/0/0/0/1",
                     m_valid, m_data, m_keep, m_last, s_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        got.delete();
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'hE0 + i), i == 3, 1'b1, in_x);
        repeat (5) cycle(1'b0, 8'h00, 1'b0, 1'b1, in_x);
        tests_run++;
        if (got.size() != 1) begin
            fails++;
            $display("FAIL midreset_count: got %0d words required 1", got.size());
        end else begin
            tests_run++;
            if (got[0].d !== 32'hE3E2E1E0 || got[0].k !== 4'hF || got[0].l !== 1'b1) begin
                fails++;
                $display("FAIL midreset_word: got %h/%b/%b required e3e2e1e0/1111/1",
                         got[0].d, got[0].k, got[0].l);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] in_b[$];
        logic       in_l[$];
        word_t      exp_w[$];
        logic [7:0] rec_b[$];
        logic       in_x;
        int         n, idx, c, bad, pos;
        do_reset();
        // Reference: each packet is chopped into B-byte chunks; the final chunk carries last.
        for (int p = 0; p < 40; p++) begin
            int len = int'($urandom_range(1, 9));
            for (int off = 0; off < len; off += B) begin
                word_t w;
                int    cnt = (len - off < B) ? (len - off) : B;
                w.d = '0; w.k = '0;
                for (int j = 0; j < cnt; j++) begin
                    logic [7:0] b = 8'($urandom);
                    w.d = w.d | ((8*B)'(b) << (8 * j));
                    w.k[j] = 1'b1;
                    in_b.push_back(b);
                    in_l.push_back(off + j == len - 1);
                end
                w.l = (off + cnt == len);
                exp_w.push_back(w);
            end
        end
        n = in_b.size();
        idx = 0;
        c = 0;
        while ((idx < n || got.size() < exp_w.size()) && c < 20000) begin
            logic sv = (idx < n) && ($urandom_range(0, 3) != 0);
            logic mr = ($urandom_range(0, 2) != 0);
            cycle(sv, (idx < n) ? in_b[idx] : 8'h00, (idx < n) ? in_l[idx] : 1'b0, mr, in_x);
            if (in_x) idx++;
            c++;
        end
        repeat (8) cycle(1'b0, 8'h00, 1'b0, 1'b1, in_x);
        tests_run++;
        if (idx != n || got.size() != exp_w.size()) begin
            fails++;
            $display("FAIL rand_count: got bytes=%0d words=%0d required bytes=%0d words=%0d",
                     idx, got.size(), n, exp_w.size());
        end
        bad = 0;
        for (int i = 0; i < got.size() && i < exp_w.size(); i++) begin
            if (got[i].d !== exp_w[i].d || got[i].k !== exp_w[i].k || got[i].l !== exp_w[i].l) begin
                if (bad == 0)
                    $display("FAIL rand_word[%0d]: got %h/%b/%b required %h/%b/%b", i,
                             got[i].d, got[i].k, got[i].l, exp_w[i].d, exp_w[i].k, exp_w[i].l);
                bad++;
            end
        end
        tests_run++;
        if (bad != 0) begin
            fails++;
            $display("FAIL rand_words: got %0d mismatching words required 0", bad);
        end
        bad = 0;
        pos = 0;
        for (int i = 0; i < got.size(); i++) begin
            for (int k = 0; k < B; k++) begin
                if (got[i].k[k]) begin
                    logic [8*B-1:0] tmp = got[i].d >> (8 * k);
                    rec_b.push_back(tmp[7:0]);
                    pos++;
                end
            end
            if (got[i].l && (pos == 0 || pos > n || !in_l[pos-1])) bad++;
        end
        tests_run++;
        if (rec_b != in_b) begin
            fails++;
            $display("FAIL rand_stream: got %0d reconstructed bytes required %0d identical bytes",
                     rec_b.size(), n);
        end
        tests_run++;
        if (bad != 0) begin
            fails++;
            $display("FAIL rand_last_placement: got %0d misplaced last flags required 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_partial();
        test_back_pressure();
        test_single_byte();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
